// File: rtl/reset_sequencer.sv
// reset_sequencer
//
// Staged reset release for the core subsystems after power-on, a watchdog
// timeout or a user/OSD reset request. All three domain resets are held for
// HOLD_CYCLES, then the SDRAM controller is released and given up to
// MEM_TIMEOUT cycles to report mem_ready. Video is released next, followed
// STAGE_CYCLES later by the CPU/audio domain. Once running, the watchdog is
// masked for GRACE_CYCLES so a core that has not yet produced vsync is not
// immediately reset again.
//
// Optional feature macro: RSTSEQ_CAUSE_LOG_EN
//   defined     : trip_count / last_cause registers record reset causes.
//   not defined : trip_count = 0, last_cause = 0; sequencing is unchanged.
//
// Ports:
//   clk        in   system clock (27 MHz)
//   reset      in   asynchronous active-high restart
//   wdt_trip   in   watchdog sys_reset level
//   sw_req     in   single-cycle user reset request
//   mem_ready  in   SDRAM init complete (level)
//   rst_mem    out  SDRAM controller reset, active-high
//   rst_video  out  video pipeline reset, active-high
//   rst_cpu    out  CPU/audio reset, active-high
//   busy       out  high whenever the sequencer is not in RUN
//   trip_count out  saturating count of watchdog-caused resets
//   last_cause out  0 power-on/reset, 1 watchdog, 2 sw_req, 3 memory timeout

module reset_sequencer #(
  parameter int HOLD_CYCLES  = 270,
  parameter int STAGE_CYCLES = 27,
  parameter int MEM_TIMEOUT  = 2_700_000,
  parameter int GRACE_CYCLES = 13_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wdt_trip,
  input  logic       sw_req,
  input  logic       mem_ready,
  output logic       rst_mem,
  output logic       rst_video,
  output logic       rst_cpu,
  output logic       busy,
  output logic [7:0] trip_count,
  output logic [1:0] last_cause
);

  typedef enum logic [1:0] {
    ASSERT    = 2'd0,
    WAIT_MEM  = 2'd1,
    REL_VIDEO = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [23:0] HOLD_LAST  = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] STAGE_LAST = 24'(STAGE_CYCLES - 1);
  localparam logic [23:0] MEM_LAST   = 24'(MEM_TIMEOUT - 1);
  localparam logic [23:0] GRACE_MAX  = 24'(GRACE_CYCLES);

  state_t      state;
  logic [23:0] cnt;
  logic        wdt_fire;
  logic        sw_fire;

  // In RUN the counter parks at GRACE_MAX, so reaching it marks the end of
  // the watchdog grace window.
  assign wdt_fire = (state == RUN) && (cnt == GRACE_MAX) && wdt_trip;
  // A request during ASSERT is dropped so it cannot stretch the hold.
  assign sw_fire  = (state != ASSERT) && sw_req;

  // Outputs are registered from the current state, so every reset edge lags
  // the state transition that causes it by exactly one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ASSERT;
      cnt       <= '0;
      rst_mem   <= 1'b1;
      rst_video <= 1'b1;
      rst_cpu   <= 1'b1;
      busy      <= 1'b1;
    end else begin
      rst_mem   <= (state == ASSERT);
      rst_video <= (state == ASSERT) || (state == WAIT_MEM);
      rst_cpu   <= (state != RUN);
      busy      <= (state != RUN);

      if (wdt_fire || sw_fire) begin
        state <= ASSERT;
        cnt   <= '0;
      end else begin
        unique case (state)
          ASSERT: begin
            if (cnt == HOLD_LAST) begin
              state <= WAIT_MEM;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 24'd1;
            end
          end
          WAIT_MEM: begin
            // mem_ready wins over a timeout landing on the same cycle.
            if (mem_ready) begin
              state <= REL_VIDEO;
              cnt   <= '0;
            end else if (cnt == MEM_LAST) begin
              state <= ASSERT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 24'd1;
            end
          end
          REL_VIDEO: begin
            if (cnt == STAGE_LAST) begin
              state <= RUN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 24'd1;
            end
          end
          RUN: begin
            if (cnt != GRACE_MAX) begin
              cnt <= cnt + 24'd1;
            end
          end
          default: begin
            state <= ASSERT;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

`ifdef RSTSEQ_CAUSE_LOG_EN
  logic mem_timeout;

  // A user request in WAIT_MEM pre-empts a coincident timeout.
  assign mem_timeout = (state == WAIT_MEM) && !mem_ready && (cnt == MEM_LAST) && !sw_fire;

  // Cause priority: watchdog, then user request, then memory timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trip_count <= '0;
      last_cause <= 2'd0;
    end else if (wdt_fire) begin
      last_cause <= 2'd1;
      if (trip_count != 8'hFF) begin
        trip_count <= trip_count + 8'd1;
      end
    end else if (sw_fire) begin
      last_cause <= 2'd2;
    end else if (mem_timeout) begin
      last_cause <= 2'd3;
    end
  end
`else
  assign trip_count = 8'd0;
  assign last_cause = 2'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//
// Directed bench for reset_sequencer with HOLD=4, STAGE=2, MEM_TIMEOUT=10,
// GRACE=8. Expected output words are queued with the edge at which they are
// due whenever stimulus is driven, and compared as each edge is reached.
// Expected cause/count values collapse to zero when RSTSEQ_CAUSE_LOG_EN is
// not defined.

module tb_reset_sequencer;

  logic       clk;
  logic       reset;
  logic       wdt_trip;
  logic       sw_req;
  logic       mem_ready;
  logic       rst_mem;
  logic       rst_video;
  logic       rst_cpu;
  logic       busy;
  logic [7:0] trip_count;
  logic [1:0] last_cause;

  reset_sequencer #(
    .HOLD_CYCLES (4),
    .STAGE_CYCLES(2),
    .MEM_TIMEOUT (10),
    .GRACE_CYCLES(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wdt_trip  (wdt_trip),
    .sw_req    (sw_req),
    .mem_ready (mem_ready),
    .rst_mem   (rst_mem),
    .rst_video (rst_video),
    .rst_cpu   (rst_cpu),
    .busy      (busy),
    .trip_count(trip_count),
    .last_cause(last_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    string       tag;
    logic [13:0] exp;
    logic [13:0] mask;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edgeNo = 0;
  int   tcExp  = 0;

  function automatic logic [7:0] tz(int n);
    logic [7:0] v;
    v = 8'(n);
`ifndef RSTSEQ_CAUSE_LOG_EN
    v = 8'd0;
`endif
    return v;
  endfunction

  function automatic logic [1:0] cz(logic [1:0] c);
    logic [1:0] v;
    v = c;
`ifndef RSTSEQ_CAUSE_LOG_EN
    v = 2'd0;
`endif
    return v;
  endfunction

  // rsts = {rst_mem, rst_video, rst_cpu, busy}; full=0 checks resets only.
  task automatic applyStimulus(input int due, input string tag, input logic [3:0] rsts,
                               input int tc, input logic [1:0] cause, input bit full);
    exp_t e;
    e.due  = due;
    e.tag  = tag;
    e.exp  = {rsts, tz(tc), cz(cause)};
    e.mask = full ? 14'h3FFF : 14'h3C00;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [13:0] obs;
    e   = sb.pop_front();
    obs = {rst_mem, rst_video, rst_cpu, busy, trip_count, last_cause};
    checks++;
    assert ((obs & e.mask) === (e.exp & e.mask)) else begin
      errors++;
      $error("[TB] FAIL %s edge %0d: observed rst/busy=%b tc=%0d cause=%0d expected rst/busy=%b tc=%0d cause=%0d (mask %h)",
             e.tag, edgeNo, obs[13:10], obs[9:2], obs[1:0], e.exp[13:10], e.exp[9:2], e.exp[1:0], e.mask);
    end
  endtask

  task automatic drain();
    while (sb.size() > 0 && sb[0].due <= edgeNo) checkOutput();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edgeNo++;
    drain();
  endtask

  task automatic stepTo(input int n);
    while (edgeNo < n) step();
  endtask

  // Standard release from an ASSERT entry at edge a, mem_ready high.
  task automatic pushSeq(input int a, input int from, input string tag, input int tc,
                         input logic [1:0] cause);
    logic [3:0] r;
    for (int k = from; k <= 8; k++) begin
      if (k <= 4)      r = 4'b1111;
      else if (k == 5) r = 4'b0111;
      else if (k <= 7) r = 4'b0011;
      else             r = 4'b0000;
      applyStimulus(a + k, $sformatf("%s+%0d", tag, k), r, tc, cause, 1'b1);
    end
  endtask

  int a, r, s, u, v, w, f, x;

  initial begin
    reset = 1'b1; wdt_trip = 1'b0; sw_req = 1'b0; mem_ready = 1'b1;
    step(); step();
    applyStimulus(edgeNo, "reset_state", 4'b1111, 0, 2'd0, 1'b1);
    drain();

    // Power-on release.
    reset = 1'b0;
    a = edgeNo;
    pushSeq(a, 1, "por", 0, 2'd0);
    stepTo(a + 8);

    // Watchdog held high from RUN entry: masked until the grace window ends.
    r = a + 7;
    wdt_trip = 1'b1;
    for (int k = 2; k <= 8; k++) applyStimulus(r + k, "grace_mask", 4'b0000, 0, 2'd0, 1'b1);
    applyStimulus(r + 9, "grace_fire_edge", 4'b0000, 0, 2'd0, 1'b0);
    stepTo(r + 9);
    wdt_trip = 1'b0;
    tcExp = 1;
    pushSeq(r + 9, 1, "wdt_hold", tcExp, 2'd1);
    stepTo(r + 17);

    // Memory timeout: entered via a user request from RUN with mem_ready low.
    mem_ready = 1'b0; sw_req = 1'b1;
    s = edgeNo + 1;
    applyStimulus(s, "sw_run_edge", 4'b0000, tcExp, 2'd2, 1'b0);
    for (int k = 1; k <= 4; k++)   applyStimulus(s + k, "to_hold", 4'b1111, tcExp, 2'd2, 1'b1);
    for (int k = 5; k <= 13; k++)  applyStimulus(s + k, "to_wait_mem", 4'b0111, tcExp, 2'd2, 1'b1);
    applyStimulus(s + 14, "to_fire_edge", 4'b0111, tcExp, 2'd2, 1'b0);
    for (int k = 15; k <= 18; k++) applyStimulus(s + k, "to_rehold", 4'b1111, tcExp, 2'd3, 1'b1);
    for (int k = 19; k <= 20; k++) applyStimulus(s + k, "to_rewait", 4'b0111, tcExp, 2'd3, 1'b1);
    step();
    sw_req = 1'b0;
    stepTo(s + 20);
    mem_ready = 1'b1;
    applyStimulus(s + 21, "to_mem_ok", 4'b0111, tcExp, 2'd3, 1'b1);
    applyStimulus(s + 22, "to_rel", 4'b0011, tcExp, 2'd3, 1'b1);
    applyStimulus(s + 23, "to_rel", 4'b0011, tcExp, 2'd3, 1'b1);
    applyStimulus(s + 24, "to_run", 4'b0000, tcExp, 2'd3, 1'b1);
    stepTo(s + 21);
    mem_ready = 1'b0;
    stepTo(s + 24);
    mem_ready = 1'b1;

    // User reset during REL_VIDEO, plus an ignored request during the hold.
    sw_req = 1'b1;
    u = edgeNo + 1;
    applyStimulus(u, "usr_run_edge", 4'b0000, tcExp, 2'd2, 1'b0);
    for (int k = 1; k <= 4; k++) applyStimulus(u + k, "usr_pre_hold", 4'b1111, tcExp, 2'd2, 1'b1);
    applyStimulus(u + 5, "usr_pre_wait", 4'b0111, tcExp, 2'd2, 1'b1);
    step();
    sw_req = 1'b0;
    stepTo(u + 5);
    sw_req = 1'b1;
    v = u + 6;
    applyStimulus(v, "usr_relvid_edge", 4'b0011, tcExp, 2'd2, 1'b0);
    step();
    sw_req = 1'b0;
    pushSeq(v, 1, "usr_hold", tcExp, 2'd2);
    stepTo(v + 1);
    sw_req = 1'b1;
    step();
    sw_req = 1'b0;
    stepTo(v + 8);

    // Simultaneous sw_req and honoured watchdog: watchdog wins.
    for (int k = 9; k <= 15; k++) applyStimulus(v + k, "sim_grace", 4'b0000, tcExp, 2'd2, 1'b1);
    stepTo(v + 15);
    wdt_trip = 1'b1; sw_req = 1'b1;
    w = v + 16;
    applyStimulus(w, "sim_edge", 4'b0000, tcExp, 2'd2, 1'b0);
    step();
    wdt_trip = 1'b0; sw_req = 1'b0;
    tcExp++;
    pushSeq(w, 1, "sim_wdt_wins", tcExp, 2'd1);
    stepTo(w + 8);

    // Continuous watchdog: one trip every 16 edges until the count saturates.
    wdt_trip = 1'b1;
    f = w;
    for (int k = 1; k <= 254; k++) begin
      f = w + 16 * k;
      tcExp = (tcExp < 255) ? tcExp + 1 : 255;
      applyStimulus(f + 1, $sformatf("sat_trip%0d", k), 4'b1111, tcExp, 2'd1, 1'b1);
      stepTo(f + 1);
    end
    wdt_trip = 1'b0;
    pushSeq(f, 2, "sat_hold", tcExp, 2'd1);
    stepTo(f + 8);

    // Asynchronous reset asserted mid-clock during REL_VIDEO.
    sw_req = 1'b1;
    x = edgeNo + 1;
    applyStimulus(x, "ar_run_edge", 4'b0000, tcExp, 2'd1, 1'b0);
    for (int k = 1; k <= 4; k++) applyStimulus(x + k, "ar_pre_hold", 4'b1111, tcExp, 2'd2, 1'b1);
    applyStimulus(x + 5, "ar_pre_wait", 4'b0111, tcExp, 2'd2, 1'b1);
    applyStimulus(x + 6, "ar_pre_rel", 4'b0011, tcExp, 2'd2, 1'b1);
    step();
    sw_req = 1'b0;
    stepTo(x + 6);
    #3;
    reset = 1'b1;
    #1;
    applyStimulus(edgeNo, "ar_immediate", 4'b1111, 0, 2'd0, 1'b1);
    drain();
    step();
    reset = 1'b0;
    a = edgeNo;
    pushSeq(a, 1, "ar_restart", 0, 2'd0);
    stepTo(a + 8);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("[TB] FAIL queue_empty: observed %0d pending expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
